// File: rtl/b16_sram_responder_if.sv
// CPU-side request/response bus between the b16 memory port and the SRAM responder.
//   sel   : SRAM address-space decode hit
//   addr  : CPU byte address (bit 0 ignored by the responder)
//   r, w  : read request / byte write enables (w[1]=high byte, w[0]=low byte)
//   din   : write data
//   dout  : read data, valid while ready=1, held until the next read
//   ready : one-cycle completion pulse
interface b16_sram_responder_if;
    logic        sel;
    logic [15:0] addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] din;
    logic [15:0] dout;
    logic        ready;

    modport master (output sel, addr, r, w, din, input dout, ready);
    modport slave  (input sel, addr, r, w, din, output dout, ready);
endinterface

// File: rtl/b16_sram_responder.sv
// Timed asynchronous-SRAM cycle engine for the b16 CPU memory port.
// Ports:
//   i_clk, i_reset    : clock, synchronous active-high reset
//   bus (slave)       : CPU request/response bus (sel/addr/r/w/din in, dout/ready out)
//   o_sram_addr       : {ADDR_HI, latched word address}
//   i_sram_dq         : SRAM data bus input
//   o_sram_dq         : SRAM data bus output, enabled by o_sram_dq_oe
//   o_sram_*_n        : SRAM strobes (ce, oe, we, ub, lb), all active-low
module b16_sram_responder #(
    parameter int unsigned WAIT_RD = 2,
    parameter int unsigned WAIT_WR = 2,
    parameter logic [2:0]  ADDR_HI = 3'b000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    b16_sram_responder_if.slave        bus,
    output logic [17:0]                o_sram_addr,
    input  logic [15:0]                i_sram_dq,
    output logic [15:0]                o_sram_dq,
    output logic                       o_sram_dq_oe,
    output logic                       o_sram_ce_n,
    output logic                       o_sram_oe_n,
    output logic                       o_sram_we_n,
    output logic                       o_sram_ub_n,
    output logic                       o_sram_lb_n
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_RD - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WAIT_WR - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WSETUP = 3'd2;
    localparam logic [2:0] ST_WPULSE = 3'd3;
    localparam logic [2:0] ST_WHOLD  = 3'd4;
    localparam logic [2:0] ST_ACK    = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [17:0]      r_sram_addr;
    logic [15:0]      r_din;
    logic [1:0]       r_w;
    logic [15:0]      r_dout;
    logic             r_ready;
    logic             r_dq_oe;
    logic             r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_req;
    logic             w_accept;
    logic             w_capture;
    logic [1:0]       w_w_nxt;
    logic             w_ready_nxt, w_dq_oe_nxt;
    logic             w_ce_n_nxt, w_oe_n_nxt, w_we_n_nxt, w_ub_n_nxt, w_lb_n_nxt;
    logic             w_unused;

    // Address bit 0 selects a byte within the word; the SRAM is word-addressed.
    assign w_unused = bus.addr[0];
    assign w_req    = bus.sel & (bus.r | (|bus.w));

    // Next state, wait counter, and pin values for the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    w_cnt_nxt = RD_LOAD;
                    // Write wins over a simultaneous read.
                    w_state_nxt = (|bus.w) ? ST_WSETUP : ST_RD;
                end
            end
            ST_RD: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_WSETUP: begin
                w_cnt_nxt   = WR_LOAD;
                w_state_nxt = ST_WPULSE;
            end
            ST_WPULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WHOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_WHOLD: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        w_w_nxt = w_accept ? bus.w : r_w;

        // Pins are registered, so decode them from the state being entered.
        w_ready_nxt = 1'b0;
        w_dq_oe_nxt = 1'b0;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_ub_n_nxt  = 1'b1;
        w_lb_n_nxt  = 1'b1;
        case (w_state_nxt)
            ST_RD: begin
                w_ce_n_nxt = 1'b0;
                w_oe_n_nxt = 1'b0;
                w_ub_n_nxt = 1'b0;
                w_lb_n_nxt = 1'b0;
            end
            ST_WSETUP, ST_WPULSE, ST_WHOLD: begin
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
                w_we_n_nxt  = (w_state_nxt != ST_WPULSE);
                w_ub_n_nxt  = ~w_w_nxt[1];
                w_lb_n_nxt  = ~w_w_nxt[0];
            end
            ST_ACK:  w_ready_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, request latches, and registered pins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sram_addr <= '0;
            r_din       <= '0;
            r_w         <= '0;
            r_dout      <= '0;
            r_ready     <= 1'b0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_sram_addr <= {ADDR_HI, bus.addr[15:1]};
                r_din       <= bus.din;
                r_w         <= bus.w;
            end
            if (w_capture) begin
                r_dout <= i_sram_dq;
            end
            r_ready <= w_ready_nxt;
            r_dq_oe <= w_dq_oe_nxt;
            r_ce_n  <= w_ce_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_we_n  <= w_we_n_nxt;
            r_ub_n  <= w_ub_n_nxt;
            r_lb_n  <= w_lb_n_nxt;
        end
    end

    assign bus.dout     = r_dout;
    assign bus.ready    = r_ready;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_dq    = r_din;
    assign o_sram_dq_oe = r_dq_oe;
    assign o_sram_ce_n  = r_ce_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;
    assign o_sram_ub_n  = r_ub_n;
    assign o_sram_lb_n  = r_lb_n;
endmodule

// File: tb/tb_b16_sram_responder.sv
// Directed bench for b16_sram_responder with a behavioural async SRAM model.
module tb_b16_sram_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i, sram_dq_o;
    logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    always #5 clk = ~clk;

    b16_sram_responder_if u_bus ();

    b16_sram_responder #(.WAIT_RD(2), .WAIT_WR(2), .ADDR_HI(3'b000)) u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .bus          (u_bus.slave),
        .o_sram_addr  (sram_addr),
        .i_sram_dq    (sram_dq_i),
        .o_sram_dq    (sram_dq_o),
        .o_sram_dq_oe (dq_oe),
        .o_sram_ce_n  (ce_n),
        .o_sram_oe_n  (oe_n),
        .o_sram_we_n  (we_n),
        .o_sram_ub_n  (ub_n),
        .o_sram_lb_n  (lb_n)
    );

    // Async SRAM model: reads while ce/oe low, byte writes while ce/we low.
    logic [15:0] mem [0:32767];
    assign sram_dq_i = (!ce_n && !oe_n) ? mem[sram_addr[14:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (!ce_n && !we_n && dq_oe) begin
            if (!ub_n) mem[sram_addr[14:0]][15:8] <= sram_dq_o[15:8];
            if (!lb_n) mem[sram_addr[14:0]][7:0]  <= sram_dq_o[7:0];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int n_clash = 0;

    always @(negedge clk) begin
        if (dq_oe && !oe_n) n_clash++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle traces of one transaction; bit c = asserted in cycle c.
    logic [15:0] tr_oe, tr_we, tr_dqoe;
    logic        tr_ub, tr_lb;

    task automatic run_txn(input logic rd, input logic [1:0] wr, input logic [15:0] a,
                           input logic [15:0] d, input bit drop, input string tag,
                           output int lat, output logic [15:0] got, output logic [17:0] sa);
        @(negedge clk);
        u_bus.sel = 1'b1; u_bus.r = rd; u_bus.w = wr; u_bus.addr = a; u_bus.din = d;
        lat = 0; got = '0; sa = '0;
        tr_oe = '0; tr_we = '0; tr_dqoe = '0; tr_ub = 1'b1; tr_lb = 1'b1;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            tr_oe[c[3:0]]   = ~oe_n;
            tr_we[c[3:0]]   = ~we_n;
            tr_dqoe[c[3:0]] = dq_oe;
            if (c == 1) begin
                tr_ub = ub_n; tr_lb = lb_n; sa = sram_addr;
                if (drop) begin u_bus.sel = 1'b0; u_bus.r = 1'b0; u_bus.w = 2'b00; end
            end
            if (u_bus.ready) begin
                lat = c; got = u_bus.dout;
                break;
            end
        end
        u_bus.sel = 1'b0; u_bus.r = 1'b0; u_bus.w = 2'b00;
        if (lat == 0) begin
            check({tag, "_timeout"}, 32'(lat), 32'(1));
        end else begin
            @(negedge clk);
            check({tag, "_ready_one_cycle"}, 32'(u_bus.ready), 32'(0));
            check({tag, "_dout_held"}, 32'(u_bus.dout), 32'(got));
        end
    endtask

    typedef struct packed {
        logic        rd;
        logic [1:0]  wr;
        logic [15:0] a;
        logic [15:0] d;
        int          lat;
        logic [15:0] dout;
        logic [17:0] sa;
        logic [15:0] oe_m;
        logic [15:0] we_m;
        logic [15:0] dqoe_m;
        logic        ub;
        logic        lb;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          lat;
        logic [15:0] got;
        logic [17:0] sa;
        int          rdy_cnt;

        // WAIT_RD=2: oe low cycles 1-2, ready 3. WAIT_WR=2: dq_oe 1-4, we low 2-3, ready 5.
        vecs[0] = '{1'b1, 2'b00, 16'h04A6, 16'h0000, 3, 16'hBEEF, 18'h00253, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b10, 16'h0010, 16'h12AB, 5, 16'h0000, 18'h00008, 16'h0000, 16'h000C, 16'h001E, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 2'b00, 16'h0010, 16'h0000, 3, 16'h1256, 18'h00008, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'b01, 16'h0011, 16'h77CD, 5, 16'h0000, 18'h00008, 16'h0000, 16'h000C, 16'h001E, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 2'b00, 16'h0011, 16'h0000, 3, 16'h12CD, 18'h00008, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b11, 16'h0100, 16'h5A5A, 5, 16'h0000, 18'h00080, 16'h0000, 16'h000C, 16'h001E, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 2'b00, 16'h0100, 16'h0000, 3, 16'h5A5A, 18'h00080, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 2'b11, 16'h0200, 16'hA5C3, 5, 16'h0000, 18'h00100, 16'h0000, 16'h000C, 16'h001E, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 2'b00, 16'h0200, 16'h0000, 3, 16'hA5C3, 18'h00100, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 2'b00, 16'hFFFE, 16'h0000, 3, 16'hFACE, 18'h07FFF, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[15'h0253] = 16'hBEEF;
        mem[15'h0008] = 16'h3456;
        mem[15'h7FFF] = 16'hFACE;

        // Reset held with a pending read: nothing may move.
        reset = 1'b1;
        u_bus.sel = 1'b1; u_bus.r = 1'b1; u_bus.w = 2'b00;
        u_bus.addr = 16'h04A6; u_bus.din = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ready", 32'(u_bus.ready), 32'(0));
            check("rst_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'(5'b11111));
            check("rst_dq_oe", 32'(dq_oe), 32'(0));
            check("rst_addr_dout", 32'({sram_addr, u_bus.dout}), 32'(0));
        end
        reset = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (u_bus.ready) begin lat = c; break; end
        end
        check("rst_release_lat", 32'(lat), 32'(3));
        check("rst_release_dout", 32'(u_bus.dout), 32'(16'hBEEF));
        u_bus.sel = 1'b0; u_bus.r = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0, $sformatf("v%0d", i), lat, got, sa);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_addr", i), 32'(sa), 32'(vecs[i].sa));
            check($sformatf("v%0d_oe_mask", i), 32'(tr_oe), 32'(vecs[i].oe_m));
            check($sformatf("v%0d_we_mask", i), 32'(tr_we), 32'(vecs[i].we_m));
            check($sformatf("v%0d_dqoe_mask", i), 32'(tr_dqoe), 32'(vecs[i].dqoe_m));
            check($sformatf("v%0d_ub_lb", i), 32'({tr_ub, tr_lb}), 32'({vecs[i].ub, vecs[i].lb}));
            if (vecs[i].wr == 2'b00)
                check($sformatf("v%0d_dout", i), 32'(got), 32'(vecs[i].dout));
        end

        // Request dropped right after acceptance still completes.
        run_txn(1'b1, 2'b00, 16'h04A6, 16'h0000, 1'b1, "drop", lat, got, sa);
        check("drop_lat", 32'(lat), 32'(3));
        check("drop_dout", 32'(got), 32'(16'hBEEF));

        // Reset asserted during the write pulse aborts cleanly.
        @(negedge clk);
        u_bus.sel = 1'b1; u_bus.r = 1'b0; u_bus.w = 2'b11;
        u_bus.addr = 16'h0300; u_bus.din = 16'h1111;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wpulse", 32'({we_n, dq_oe}), 32'(2'b01));
        reset = 1'b1;
        @(negedge clk);
        check("abort_we_dq", 32'({we_n, dq_oe, ce_n}), 32'(3'b101));
        check("abort_ready", 32'(u_bus.ready), 32'(0));
        reset = 1'b0;
        u_bus.sel = 1'b0; u_bus.w = 2'b00;
        rdy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (u_bus.ready) rdy_cnt++;
        end
        check("abort_no_ready", 32'(rdy_cnt), 32'(0));

        // Engine is back in IDLE and serves a normal read.
        run_txn(1'b1, 2'b00, 16'h0010, 16'h0000, 1'b0, "post_abort", lat, got, sa);
        check("post_abort_lat", 32'(lat), 32'(3));
        check("post_abort_dout", 32'(got), 32'(16'h12CD));

        check("no_bus_clash", 32'(n_clash), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
